// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
// Shared types and helpers for the frame-aware pattern generator.
//   mode_e     : pattern select encoding (6 and 7 are reserved and output zero)
//   state_e    : frame/line sequencing states
//   lfsr_taps  : maximal-length Fibonacci tap mask for widths 8..16
//                (bit n-1 set means polynomial term x^n is present)
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        MODE_CONST = 3'd0,
        MODE_HRAMP = 3'd1,
        MODE_VRAMP = 3'd2,
        MODE_DIAG  = 3'd3,
        MODE_CHECK = 3'd4,
        MODE_PRBS  = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_LINE      = 2'd2
    } state_e;

    // Returns zero for an unsupported width; the top rejects such widths
    // at elaboration so a zero mask never reaches hardware.
    function automatic logic [15:0] lfsr_taps(int dw);
        case (dw)
            8:       lfsr_taps = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       lfsr_taps = 16'h0110;  // x^9+x^5+1
            10:      lfsr_taps = 16'h0240;  // x^10+x^7+1
            11:      lfsr_taps = 16'h0500;  // x^11+x^9+1
            12:      lfsr_taps = 16'h0829;  // x^12+x^6+x^4+x+1
            13:      lfsr_taps = 16'h100D;  // x^13+x^4+x^3+x+1
            14:      lfsr_taps = 16'h2015;  // x^14+x^5+x^3+x+1
            15:      lfsr_taps = 16'h6000;  // x^15+x^14+1
            16:      lfsr_taps = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/pattern_gen_frame_lfsr.sv
// -----------------------------------------------------------------------------
// pg_lfsr
// Fibonacci LFSR used for the PRBS pattern. The register value is the next
// pixel to be emitted; it shifts left with the XOR of the tapped bits entering
// at bit 0.
//   clk, rst_n : clock, asynchronous active-low reset (clears the register)
//   load       : load seed (has priority over advance)
//   seed       : DW-bit seed value
//   advance    : step the sequence by one
//   q          : current LFSR value
// -----------------------------------------------------------------------------
module pg_lfsr
    import pattern_gen_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] seed,
    input  logic          advance,
    output logic [DW-1:0] q
);

    localparam logic [15:0]   TAPS_ALL = lfsr_taps(DW);
    localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];

    logic [DW-1:0] lfsr_q, lfsr_d;

    always_comb begin
        // NOTE: assign a default first so every path drives lfsr_d and no latch is inferred.
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (advance) begin
            lfsr_d = {lfsr_q[DW-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pattern_gen_frame.sv
// -----------------------------------------------------------------------------
// pattern_gen_frame
// Frame-aware test pattern generator. f_sync latches the configuration and arms
// line 0; each sync then emits one line of H_ACTIVE pixels, V_ACTIVE lines per
// frame. All outputs are registered.
//   clk, rst_n       : clock, asynchronous active-low reset
//   f_sync           : frame start (latches const_val/dx/dy/mode, clears x/y)
//   sync             : line start
//   const_val        : constant / ramp base / checker colour / PRBS seed
//   dx, dy           : ramp steps, also checker cell size exponents (minus 2)
//   mode             : pattern select (see pattern_gen_pkg::mode_e)
//   pix_data         : pixel value, zero when not valid
//   pix_valid        : pix_data qualifier
//   line_end         : with the last pixel of each line
//   frame_end        : with the last pixel of the last line
//   sync_err         : sync rejected mid-line
//   busy             : frame armed or active
// -----------------------------------------------------------------------------
module pattern_gen_frame
    import pattern_gen_pkg::*;
#(
    parameter int DW       = 12,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_sync,
    input  logic          sync,
    input  logic [DW-1:0] const_val,
    input  logic [1:0]    dx,
    input  logic [1:0]    dy,
    input  logic [2:0]    mode,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          line_end,
    output logic          frame_end,
    output logic          sync_err,
    output logic          busy
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    if (DW < 8 || DW > 16) begin : g_bad_dw
        $error("pattern_gen_frame: DW must be in 8..16");
    end
    if (H_ACTIVE < 2 || V_ACTIVE < 1) begin : g_bad_geometry
        $error("pattern_gen_frame: H_ACTIVE must be >= 2 and V_ACTIVE >= 1");
    end

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [DW-1:0] h_acc_q, h_acc_d;     // x * dx, built by repeated addition
    logic [DW-1:0] v_acc_q, v_acc_d;     // y * dy, built by repeated addition
    logic [DW-1:0] const_q, const_d;
    logic [1:0]    dx_q, dx_d;
    logic [1:0]    dy_q, dy_d;
    logic [2:0]    mode_q, mode_d;

    logic [DW-1:0] pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;
    logic          sync_err_q, sync_err_d;
    logic          busy_q, busy_d;

    logic          emit;                 // a pixel is registered this cycle
    logic          lfsr_load;
    logic [DW-1:0] lfsr_seed;
    logic [DW-1:0] lfsr_val;
    logic [DW-1:0] dx_ext, dy_ext;
    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;

    assign dx_ext    = {{(DW-2){1'b0}}, dx_q};
    assign dy_ext    = {{(DW-2){1'b0}}, dy_q};
    assign lfsr_seed = (const_val == '0) ? {{(DW-1){1'b0}}, 1'b1} : const_val;

    // Checker cell indices of the pixel being emitted (x_d/y_d hold its coordinates).
    assign cell_x = x_d >> ({1'b0, dx_q} + 3'd2);
    assign cell_y = y_d >> ({1'b0, dy_q} + 3'd2);

    pg_lfsr #(.DW(DW)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .advance (emit),
        .q       (lfsr_val)
    );

    // Sequencing. x_q/y_q and the accumulators always describe the pixel
    // currently on the output, so the "last pixel" test is x_q == X_LAST.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        h_acc_d     = h_acc_q;
        v_acc_d     = v_acc_q;
        const_d     = const_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        mode_d      = mode_q;
        emit        = 1'b0;
        lfsr_load   = 1'b0;
        sync_err_d  = 1'b0;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;

        if (f_sync) begin
            // f_sync outranks everything, including a same-cycle sync and an
            // in-progress line (which is aborted without end markers).
            const_d   = const_val;
            dx_d      = dx;
            dy_d      = dy;
            mode_d    = mode;
            x_d       = '0;
            y_d       = '0;
            h_acc_d   = '0;
            v_acc_d   = '0;
            lfsr_load = 1'b1;
            state_d   = ST_WAIT_LINE;
        end else begin
            case (state_q)
                ST_WAIT_LINE: begin
                    if (sync) begin
                        state_d = ST_LINE;
                        emit    = 1'b1;
                        x_d     = '0;
                        h_acc_d = '0;
                    end
                end
                ST_LINE: begin
                    if (x_q != X_LAST) begin
                        emit       = 1'b1;
                        x_d        = x_q + 1'b1;
                        h_acc_d    = h_acc_q + dx_ext;
                        sync_err_d = sync;
                    end else if (y_q == Y_LAST) begin
                        state_d    = ST_IDLE;
                        sync_err_d = sync;
                    end else begin
                        y_d     = y_q + 1'b1;
                        v_acc_d = v_acc_q + dy_ext;
                        x_d     = '0;
                        h_acc_d = '0;
                        // A sync on the last pixel starts the next line with no gap.
                        if (sync) begin
                            emit = 1'b1;
                        end else begin
                            state_d = ST_WAIT_LINE;
                        end
                    end
                end
                default: ;  // ST_IDLE: sync is ignored silently
            endcase
        end

        if (emit) begin
            line_end_d  = (x_d == X_LAST);
            frame_end_d = line_end_d && (y_d == Y_LAST);
        end
        pix_valid_d = emit;
        busy_d      = (state_d != ST_IDLE);
    end

    // Pixel value for the emitted coordinates, using the latched configuration.
    always_comb begin
        pix_data_d = '0;
        if (emit) begin
            case (mode_q)
                MODE_CONST: pix_data_d = const_q;
                MODE_HRAMP: pix_data_d = const_q + h_acc_d;
                MODE_VRAMP: pix_data_d = const_q + v_acc_d;
                MODE_DIAG:  pix_data_d = const_q + h_acc_d + v_acc_d;
                MODE_CHECK: pix_data_d = (cell_x[0] ^ cell_y[0]) ? ~const_q : const_q;
                MODE_PRBS:  pix_data_d = lfsr_val;
                default:    pix_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            h_acc_q     <= '0;
            v_acc_q     <= '0;
            const_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            mode_q      <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            sync_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            h_acc_q     <= h_acc_d;
            v_acc_q     <= v_acc_d;
            const_q     <= const_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            mode_q      <= mode_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            sync_err_q  <= sync_err_d;
            busy_q      <= busy_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;
    assign sync_err  = sync_err_q;
    assign busy      = busy_q;

endmodule

// File: doc/pattern_gen_frame.md
# pattern_gen_frame

Parametrised, frame-aware successor to the 12-bit single-counter pattern generator. It produces one pixel word per clock across a configurable H_ACTIVE × V_ACTIVE frame. Frames are armed by `f_sync` and lines are started by `sync`. Modes are constant, H/V/diagonal ramp, checkerboard and PRBS. It sits between the timing/sync source and the video/data-path under test, and drives qualified pixel data plus line and frame markers.

## Interface
- `DW`, 12: pixel word width; supported range 8..16.
- `H_ACTIVE`, 1024: pixels per line; must be ≥ 2.
- `V_ACTIVE`, 768: lines per frame; must be ≥ 1.
- `clk`  in  1  master clock; one clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `f_sync`  in  1  frame-start pulse; latches configuration and arms line 0.
- `sync`  in  1  line-start pulse.
- `const_val`  in  DW  constant, ramp base, checkerboard colour or PRBS seed.
- `dx`  in  2  horizontal step; also the checkerboard cell width exponent.
- `dy`  in  2  vertical step; also the checkerboard cell height exponent.
- `mode`  in  3  pattern select.
- `pix_data`  out  DW  pixel value.
- `pix_valid`  out  1  `pix_data` qualifier.
- `line_end`  out  1  high with the last pixel of each line.
- `frame_end`  out  1  high with the last pixel of the last line.
- `sync_err`  out  1  one-cycle pulse when `sync` is rejected mid-line.
- `busy`  out  1  high while a frame is armed or active.

## Operation
- States: IDLE, WAIT_LINE, LINE.
- `f_sync` from any state:
  - latches `const_val`, `dx`, `dy` and `mode`; input changes during the frame are ignored;
  - clears x/y, loads the PRBS seed, and goes to WAIT_LINE.
- WAIT_LINE + `sync` → LINE. Pixels are emitted for x = 0..H_ACTIVE-1.
- At the last pixel of a line:
  - if y < V_ACTIVE-1: go to WAIT_LINE with y+1;
  - else: go to IDLE and assert `frame_end`.
- In LINE, `sync` on the last-pixel cycle of a non-last line is accepted, giving back-to-back lines with no gap.
- In LINE, `sync` on any other cycle is ignored and `sync_err` pulses.
- `sync` in IDLE is ignored silently.
- `f_sync` and `sync` in the same cycle: `f_sync` wins and `sync` is dropped.
- `f_sync` in LINE aborts the line: `pix_valid` drops next cycle and no `line_end`/`frame_end` is given for the aborted line.
- Modes (L = latched value; all arithmetic modulo 2^DW with silent wrap):
  - 0 constant: L.const_val.
  - 1 H-ramp: const + x·dx.
  - 2 V-ramp: const + y·dy.
  - 3 diagonal: const + x·dx + y·dy.
  - 4 checkerboard: ((x>>(dx+2)) ^ (y>>(dy+2)))&1 ? ~const : const.
  - 5 PRBS: Fibonacci LFSR with the package tap mask. Seed = const, or 1 if const == 0. The first pixel of the frame is the seed. The LFSR advances on every valid pixel and continues across lines.
  - 6, 7 reserved: output 0, with `pix_valid` still asserted.
- Ramps are computed incrementally: a row-base accumulator gets +dy per line, and a pixel accumulator gets +dx per pixel. No multipliers.

## Timing
- `sync` sampled at cycle t → first `pix_valid` at t+1 → last pixel at t+H_ACTIVE. All outputs are registered.
- `f_sync` at t → `busy` high at t+1.
- `busy` drops the cycle after `frame_end`.
- `line_end` and `frame_end` coincide with `pix_valid` and are single-cycle.
- `sync_err` is asserted at t+1 after the offending `sync`.
- Reset (asynchronous, any time including mid-line):
  - all outputs go to 0 immediately and the state goes to IDLE;
  - latched config, x, y and the LFSR are cleared;
  - no output activity until the next `f_sync`.

## Structure
- `pattern_gen_pkg`:
  - `mode_e` (MODE_CONST, MODE_HRAMP, MODE_VRAMP, MODE_DIAG, MODE_CHECK, MODE_PRBS);
  - `state_e`;
  - function `lfsr_taps(int dw)` returning the tap mask for DW 8..16 (DW=12: x^12+x^6+x^4+x+1). An unsupported DW is an elaboration error.
- Sub-module `pg_lfsr` (params DW; ports clk, rst_n, load, seed, advance, q).
- Top holds the FSM, counters, accumulators and the output mux/register.

## Test plan
All scenarios use bench overrides H_ACTIVE=8, V_ACTIVE=2 unless noted.
- Mode 1, const=0x100, dx=3, one `sync` → line 0 is 0x100,0x103,…,0x115; `line_end` on the 8th pixel; `busy` stays high.
- Mode 3, const=0xFFE, dx=1, dy=2, two `sync` → line 1 pixel 0 = 0x000 (wrap), pixel 7 = 0x007; `frame_end` on the 16th pixel; `busy` low the next cycle.
- Mode 4, H=V=8, const=0x0F0, dx=dy=0 → rows 0-3: pixels 0-3 = 0x0F0, pixels 4-7 = 0xF0F; rows 4-7 inverted.
- Mode 5, const=0, DW=12, H=4095, V=1 → first pixel 0x001; sequence does not repeat within 4095 pixels; a second frame restarts at 0x001.
- Corner cases:
  - `sync` on pixel 3 → `sync_err` pulse, line unaffected;
  - `sync` on the last pixel → line 1 starts the next cycle with no gap;
  - `f_sync` on pixel 5 → `pix_valid` low the next cycle, new config latched;
  - `f_sync` and `sync` in the same cycle → no pixels.
- `rst_n` low mid-line in mode 1 → all outputs 0 immediately; after release, `sync` alone produces nothing; `f_sync` then `sync` restarts from const.
